// File: rtl/gpmc_wb_pkg.sv
// Shared types and constants for the GPMC-to-Wishbone bridge.
// Reserved offsets are counted down from the top of the GPMC window.
package gpmc_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WB,
        ST_HOLD
    } state_e;

    localparam int unsigned PAGE_FROM_TOP   = 0;
    localparam int unsigned STATUS_FROM_TOP = 1;

    localparam int STATUS_W       = 3;
    localparam int ST_ERR_BIT     = 0;
    localparam int ST_TIMEOUT_BIT = 1;
    localparam int ST_OVERRUN_BIT = 2;

endpackage

// File: rtl/gpmc_strobe_sync.sv
// Multi-flop synchroniser for one asynchronous strobe, with single-cycle
// rise/fall pulses derived from the synchronised level.
module gpmc_strobe_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // The extra top stage holds the previous synchronised value for edge detection.
    logic [SYNC_STAGES:0] sync_q;
    logic [SYNC_STAGES:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-1:0], strobe_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {(SYNC_STAGES+1){RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES];

endmodule

// File: rtl/gpmc_wb_master.sv
// GPMC (async, multiplexed) to Wishbone classic single-cycle master with a
// page register, sticky status flags and a slave-timeout abort.
module gpmc_wb_master
    import gpmc_wb_pkg::*;
#(
    parameter int                GPMC_AW     = 16,
    parameter int                DW          = 16,
    parameter int                WB_AW       = 32,
    parameter logic [WB_AW-1:0]  WB_BASE     = 32'h4000_0000,
    parameter int                SYNC_STAGES = 2,
    parameter int                TIMEOUT     = 255,
    parameter logic [DW-1:0]     ERR_DATA    = 16'hDEAD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        gpmc_ad_i,
    output logic [DW-1:0]        gpmc_ad_o,
    output logic                 gpmc_ad_oe,
    input  logic                 gpmc_advn,
    input  logic                 gpmc_csn,
    input  logic                 gpmc_wein,
    input  logic                 gpmc_oen,
    output logic [WB_AW-1:0]     wbm_adr,
    output logic [DW-1:0]        wbm_dat_w,
    input  logic [DW-1:0]        wbm_dat_r,
    output logic [DW/8-1:0]      wbm_sel,
    output logic                 wbm_we,
    output logic                 wbm_stb,
    output logic                 wbm_cyc,
    input  logic                 wbm_ack,
    input  logic                 wbm_err,
    output logic                 busy,
    output logic [STATUS_W-1:0]  status
);

    localparam logic [GPMC_AW-1:0] PAGE_OFF   = {GPMC_AW{1'b1}} - GPMC_AW'(PAGE_FROM_TOP);
    localparam logic [GPMC_AW-1:0] STATUS_OFF = {GPMC_AW{1'b1}} - GPMC_AW'(STATUS_FROM_TOP);

    logic advn_sync, advn_rise, advn_fall;
    logic csn_sync,  csn_rise,  csn_fall;
    logic wein_sync, wein_rise, wein_fall;
    logic oen_sync,  oen_rise,  oen_fall;
    logic unused_edges;

    gpmc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_advn (
        .clk(clk), .reset(reset), .strobe_i(gpmc_advn),
        .sync_o(advn_sync), .rise_o(advn_rise), .fall_o(advn_fall)
    );
    gpmc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .reset(reset), .strobe_i(gpmc_csn),
        .sync_o(csn_sync), .rise_o(csn_rise), .fall_o(csn_fall)
    );
    gpmc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wein (
        .clk(clk), .reset(reset), .strobe_i(gpmc_wein),
        .sync_o(wein_sync), .rise_o(wein_rise), .fall_o(wein_fall)
    );
    gpmc_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_oen (
        .clk(clk), .reset(reset), .strobe_i(gpmc_oen),
        .sync_o(oen_sync), .rise_o(oen_rise), .fall_o(oen_fall)
    );

    assign unused_edges = ^{advn_sync, advn_fall, csn_rise, csn_fall, wein_rise, oen_rise};

    state_e               state_q,  state_d;
    logic [GPMC_AW-1:0]   addr_q,   addr_d;
    logic [DW-1:0]        page_q,   page_d;
    logic [STATUS_W-1:0]  status_q, status_d;
    logic [DW-1:0]        dat_w_q,  dat_w_d;
    logic [DW-1:0]        ad_o_q,   ad_o_d;
    logic                 we_q,     we_d;
    logic [15:0]          tmo_q,    tmo_d;

    logic addr_edge;
    logic tmo_hit;

    assign addr_edge = advn_rise & ~csn_sync;
    assign tmo_hit   = (tmo_q == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            page_q   <= '0;
            status_q <= '0;
            dat_w_q  <= '0;
            ad_o_q   <= '0;
            we_q     <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            page_q   <= page_d;
            status_q <= status_d;
            dat_w_q  <= dat_w_d;
            ad_o_q   <= ad_o_d;
            we_q     <= we_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        page_d   = page_q;
        status_d = status_q;
        dat_w_d  = dat_w_q;
        ad_o_d   = ad_o_q;
        we_d     = we_q;
        tmo_d    = tmo_q;

        // A new address phase while a transfer is still in flight is dropped.
        if ((state_q == ST_WB || state_q == ST_HOLD) && addr_edge) begin
            status_d[ST_OVERRUN_BIT] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (addr_edge) begin
                    addr_d  = gpmc_ad_i[GPMC_AW-1:0];
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (csn_sync) begin
                    state_d = ST_IDLE;
                end else if (advn_rise) begin
                    addr_d = gpmc_ad_i[GPMC_AW-1:0];
                end else if (wein_fall) begin
                    we_d    = 1'b1;
                    dat_w_d = gpmc_ad_i;
                    if (addr_q == PAGE_OFF) begin
                        page_d  = gpmc_ad_i;
                        state_d = ST_HOLD;
                    end else if (addr_q == STATUS_OFF) begin
                        status_d = status_q & ~gpmc_ad_i[STATUS_W-1:0];
                        state_d  = ST_HOLD;
                    end else begin
                        tmo_d   = '0;
                        state_d = ST_WB;
                    end
                end else if (oen_fall) begin
                    we_d = 1'b0;
                    if (addr_q == PAGE_OFF) begin
                        ad_o_d  = page_q;
                        state_d = ST_HOLD;
                    end else if (addr_q == STATUS_OFF) begin
                        ad_o_d  = DW'(status_q);
                        state_d = ST_HOLD;
                    end else begin
                        tmo_d   = '0;
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                tmo_d = tmo_q + 16'd1;
                // Error wins over a simultaneous ack; the timeout only fires when neither arrived.
                if (wbm_err || wbm_ack || tmo_hit) begin
                    if (wbm_err) begin
                        status_d[ST_ERR_BIT] = 1'b1;
                    end else if (!wbm_ack) begin
                        status_d[ST_TIMEOUT_BIT] = 1'b1;
                    end
                    if (csn_sync) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        if (!we_q) begin
                            ad_o_d = (wbm_ack && !wbm_err) ? wbm_dat_r : ERR_DATA;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (csn_sync || (we_q ? wein_sync : oen_sync)) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign wbm_cyc   = (state_q == ST_WB);
    assign wbm_stb   = wbm_cyc;
    assign busy      = wbm_cyc;
    assign wbm_we    = we_q;
    assign wbm_sel   = '1;
    assign wbm_dat_w = dat_w_q;
    assign wbm_adr   = WB_BASE + WB_AW'({page_q, addr_q});
    assign gpmc_ad_o = ad_o_q;
    assign status    = status_q;

    // Raw strobes let the host turn the bus around without synchroniser delay.
    assign gpmc_ad_oe = (state_q == ST_HOLD) & ~we_q & ~gpmc_oen & ~gpmc_csn;

endmodule

// File: tb/tb_gpmc_wb_master.sv
// Scoreboard bench for gpmc_wb_master: directed GPMC host transactions push
// expected Wishbone cycles / read data; a monitor compares what the DUT presents.
module tb_gpmc_wb_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpmc_ad_i;
    logic [15:0] gpmc_ad_o;
    logic        gpmc_ad_oe;
    logic        gpmc_advn, gpmc_csn, gpmc_wein, gpmc_oen;
    logic [31:0] wbm_adr;
    logic [15:0] wbm_dat_w;
    logic [15:0] wbm_dat_r;
    logic [1:0]  wbm_sel;
    logic        wbm_we, wbm_stb, wbm_cyc;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;
    logic        busy;
    logic [2:0]  status;

    always #5 clk = ~clk;

    gpmc_wb_master dut (
        .clk        (clk),
        .reset      (reset),
        .gpmc_ad_i  (gpmc_ad_i),
        .gpmc_ad_o  (gpmc_ad_o),
        .gpmc_ad_oe (gpmc_ad_oe),
        .gpmc_advn  (gpmc_advn),
        .gpmc_csn   (gpmc_csn),
        .gpmc_wein  (gpmc_wein),
        .gpmc_oen   (gpmc_oen),
        .wbm_adr    (wbm_adr),
        .wbm_dat_w  (wbm_dat_w),
        .wbm_dat_r  (wbm_dat_r),
        .wbm_sel    (wbm_sel),
        .wbm_we     (wbm_we),
        .wbm_stb    (wbm_stb),
        .wbm_cyc    (wbm_cyc),
        .wbm_ack    (wbm_ack),
        .wbm_err    (wbm_err),
        .busy       (busy),
        .status     (status)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [15:0] dat;
        int          len;
    } cyc_exp_t;

    cyc_exp_t    cyc_exp_q[$];
    logic [15:0] rd_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name, input string msg);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    // Slave model: acks (and optionally errs) in the (delay+1)th clock of cyc.
    int          slave_delay  = 2;
    bit          slave_err    = 1'b0;
    bit          slave_silent = 1'b0;
    bit          force_ack    = 1'b0;
    logic [15:0] slave_data   = 16'h0000;
    int          slave_cnt    = 0;

    always @(negedge clk) begin
        if (wbm_cyc) slave_cnt = slave_cnt + 1;
        else         slave_cnt = 0;
        wbm_ack   = force_ack || (wbm_cyc && !slave_silent && slave_cnt == slave_delay + 1);
        wbm_err   = wbm_cyc && slave_err && slave_cnt == slave_delay + 1;
        wbm_dat_r = slave_data;
    end

    // Monitor: pops the scoreboard when a Wishbone cycle ends or the AD bus is driven.
    logic        cyc_prev = 1'b0;
    logic        oe_prev  = 1'b0;
    int          cyc_len  = 0;
    logic [31:0] cap_adr;
    logic        cap_we;
    logic [15:0] cap_dat;

    always @(negedge clk) begin
        cyc_exp_t    e;
        logic [15:0] rexp;
        if (wbm_cyc === 1'b1) begin
            if (!cyc_prev) begin
                cap_adr = wbm_adr;
                cap_we  = wbm_we;
                cap_dat = wbm_dat_w;
                cyc_len = 0;
                checkOutput("stb_with_cyc", 32'(wbm_stb), 32'd1);
                checkOutput("sel_all_ones", 32'(wbm_sel), 32'h3);
            end
            cyc_len++;
        end else if (cyc_prev) begin
            if (cyc_exp_q.size() == 0) begin
                reportFail("unexpected_wb_cycle", $sformatf("adr 0x%0h with no cycle expected", cap_adr));
            end else begin
                e = cyc_exp_q.pop_front();
                checkOutput("wb_adr", cap_adr, e.adr);
                checkOutput("wb_we", 32'(cap_we), 32'(e.we));
                if (e.we) checkOutput("wb_dat_w", 32'(cap_dat), 32'(e.dat));
                checkOutput("wb_cyc_len", 32'(cyc_len), 32'(e.len));
            end
        end
        cyc_prev = (wbm_cyc === 1'b1);

        if (gpmc_ad_oe === 1'b1) begin
            checkOutput("ad_oe_qualified", 32'({gpmc_oen, gpmc_csn}), 32'd0);
            if (!oe_prev) begin
                if (rd_exp_q.size() == 0) begin
                    reportFail("unexpected_ad_drive", $sformatf("ad_o 0x%0h driven with no read expected", gpmc_ad_o));
                end else begin
                    rexp = rd_exp_q.pop_front();
                    checkOutput("read_data", 32'(gpmc_ad_o), 32'(rexp));
                end
            end
        end
        oe_prev = (gpmc_ad_oe === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushCycle(input logic [31:0] adr, input logic we, input logic [15:0] dat, input int len);
        cyc_exp_t e;
        e.adr = adr; e.we = we; e.dat = dat; e.len = len;
        cyc_exp_q.push_back(e);
    endtask

    task automatic gpmcAddress(input logic [15:0] a);
        gpmc_csn  = 1'b0;
        gpmc_advn = 1'b0;
        gpmc_ad_i = a;
        tick(3);
        gpmc_advn = 1'b1;
        tick(4);
    endtask

    // One complete host access: address phase, data strobe held low_cycles, release.
    task automatic applyStimulus(input bit is_write, input logic [15:0] a, input logic [15:0] d, input int low_cycles);
        gpmcAddress(a);
        if (is_write) begin
            gpmc_ad_i = d;
            gpmc_wein = 1'b0;
            tick(low_cycles);
            gpmc_wein = 1'b1;
        end else begin
            gpmc_ad_i = 16'h0000;
            gpmc_oen  = 1'b0;
            tick(low_cycles);
            gpmc_oen  = 1'b1;
        end
        tick(4);
        gpmc_csn = 1'b1;
        tick(4);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        reset     = 1'b1;
        gpmc_ad_i = 16'h0000;
        gpmc_advn = 1'b1;
        gpmc_csn  = 1'b1;
        gpmc_wein = 1'b1;
        gpmc_oen  = 1'b1;
        tick(3);
        checkOutput("rst_cyc",    32'(wbm_cyc),    32'd0);
        checkOutput("rst_stb",    32'(wbm_stb),    32'd0);
        checkOutput("rst_we",     32'(wbm_we),     32'd0);
        checkOutput("rst_adr",    wbm_adr,         32'h4000_0000);
        checkOutput("rst_dat_w",  32'(wbm_dat_w),  32'd0);
        checkOutput("rst_ad_o",   32'(gpmc_ad_o),  32'd0);
        checkOutput("rst_ad_oe",  32'(gpmc_ad_oe), 32'd0);
        checkOutput("rst_busy",   32'(busy),       32'd0);
        checkOutput("rst_status", 32'(status),     32'd0);
        reset = 1'b0;
        tick(2);

        $display("[TB] plain write, page 0");
        slave_delay = 2;
        pushCycle(32'h4000_0010, 1'b1, 16'hA5A5, 3);
        applyStimulus(1'b1, 16'h0010, 16'hA5A5, 10);

        $display("[TB] page register and paged read");
        applyStimulus(1'b1, 16'hFFFF, 16'h0002, 8);
        rd_exp_q.push_back(16'h0002);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 8);
        slave_delay = 1;
        slave_data  = 16'h1234;
        pushCycle(32'h4002_0004, 1'b0, 16'h0000, 2);
        rd_exp_q.push_back(16'h1234);
        applyStimulus(1'b0, 16'h0004, 16'h0000, 12);
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 8);

        $display("[TB] read timeout");
        slave_silent = 1'b1;
        pushCycle(32'h4000_0008, 1'b0, 16'h0000, 256);
        rd_exp_q.push_back(16'hDEAD);
        applyStimulus(1'b0, 16'h0008, 16'h0000, 270);
        slave_silent = 1'b0;
        checkOutput("status_timeout", 32'(status), 32'h2);
        rd_exp_q.push_back(16'h0002);
        applyStimulus(1'b0, 16'hFFFE, 16'h0000, 8);
        applyStimulus(1'b1, 16'hFFFE, 16'h0002, 8);
        checkOutput("status_w1c_timeout", 32'(status), 32'h0);

        $display("[TB] ack and err together");
        slave_err   = 1'b1;
        slave_delay = 3;
        pushCycle(32'h4000_000C, 1'b0, 16'h0000, 4);
        rd_exp_q.push_back(16'hDEAD);
        applyStimulus(1'b0, 16'h000C, 16'h0000, 14);
        slave_err = 1'b0;
        checkOutput("status_err", 32'(status), 32'h1);
        applyStimulus(1'b1, 16'hFFFE, 16'h0001, 8);
        checkOutput("status_w1c_err", 32'(status), 32'h0);

        $display("[TB] advn pulse during WB");
        slave_delay = 10;
        slave_data  = 16'hBEEF;
        pushCycle(32'h4000_0020, 1'b0, 16'h0000, 11);
        rd_exp_q.push_back(16'hBEEF);
        gpmcAddress(16'h0020);
        gpmc_ad_i = 16'h0000;
        gpmc_oen  = 1'b0;
        tick(4);
        gpmc_advn = 1'b0;
        gpmc_ad_i = 16'h0099;
        tick(2);
        gpmc_advn = 1'b1;
        tick(3);
        gpmc_ad_i = 16'h0000;
        tick(12);
        gpmc_oen = 1'b1;
        tick(4);
        gpmc_csn = 1'b1;
        tick(4);
        checkOutput("adr_after_overrun", wbm_adr, 32'h4000_0020);
        checkOutput("status_overrun", 32'(status), 32'h4);
        applyStimulus(1'b1, 16'hFFFE, 16'h0004, 8);
        checkOutput("status_w1c_overrun", 32'(status), 32'h0);

        $display("[TB] csn released during WB");
        slave_delay = 8;
        slave_data  = 16'h7777;
        pushCycle(32'h4000_0030, 1'b0, 16'h0000, 9);
        gpmcAddress(16'h0030);
        gpmc_ad_i = 16'h0000;
        gpmc_oen  = 1'b0;
        tick(5);
        gpmc_csn = 1'b1;
        gpmc_oen = 1'b1;
        tick(20);
        checkOutput("ad_o_discarded", 32'(gpmc_ad_o), 32'hBEEF);
        checkOutput("busy_after_abort", 32'(busy), 32'd0);

        $display("[TB] reset one clock into a cycle");
        applyStimulus(1'b1, 16'hFFFF, 16'h0003, 8);
        slave_delay = 10;
        pushCycle(32'h4003_0040, 1'b1, 16'h1111, 2);
        gpmcAddress(16'h0040);
        gpmc_ad_i = 16'h1111;
        gpmc_wein = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (wbm_cyc === 1'b1) seen = 1'b1;
        end
        if (!seen) reportFail("reset_test_cyc_start", "wbm_cyc never rose within 20 clocks");
        tick(1);
        reset     = 1'b1;
        gpmc_wein = 1'b1;
        gpmc_csn  = 1'b1;
        gpmc_ad_i = 16'h0000;
        tick(1);
        checkOutput("midrst_cyc",    32'(wbm_cyc),    32'd0);
        checkOutput("midrst_stb",    32'(wbm_stb),    32'd0);
        checkOutput("midrst_we",     32'(wbm_we),     32'd0);
        checkOutput("midrst_adr",    wbm_adr,         32'h4000_0000);
        checkOutput("midrst_dat_w",  32'(wbm_dat_w),  32'd0);
        checkOutput("midrst_ad_o",   32'(gpmc_ad_o),  32'd0);
        checkOutput("midrst_ad_oe",  32'(gpmc_ad_oe), 32'd0);
        checkOutput("midrst_busy",   32'(busy),       32'd0);
        checkOutput("midrst_status", 32'(status),     32'd0);
        tick(1);
        reset = 1'b0;
        tick(2);
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        tick(3);
        checkOutput("late_ack_ignored", 32'(busy), 32'd0);
        slave_delay = 2;
        pushCycle(32'h4000_0050, 1'b1, 16'h5A5A, 3);
        applyStimulus(1'b1, 16'h0050, 16'h5A5A, 10);

        tick(5);
        checkOutput("cyc_scoreboard_drained", 32'(cyc_exp_q.size()), 32'd0);
        checkOutput("rd_scoreboard_drained",  32'(rd_exp_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpmc_wb_master.md
# gpmc_wb_master

Parametrised GPMC-to-Wishbone classic master for the BeagleWire LiteX designs. Samples the AM335x asynchronous multiplexed GPMC bus in the FPGA system clock domain and issues single Wishbone classic cycles into the SoC bus. A page register extends the narrow GPMC window over the full Wishbone address space, and a timeout/error path means a dead slave never hangs the host. Sits between the top-level GPMC pads (tristate handled at top) and the SoC `wb_*` slave port.

## Interface
- `GPMC_AW`, 16: GPMC word-address bits latched from `gpmc_ad_i`.
- `DW`, 16: data width of GPMC and Wishbone data buses.
- `WB_AW`, 32: Wishbone address width.
- `WB_BASE`, 32'h4000_0000: offset added to every Wishbone address.
- `SYNC_STAGES`, 2: synchroniser depth for GPMC control strobes (≥2).
- `TIMEOUT`, 255: cycles with `wbm_cyc` high and no ack/err before abort (1..65535).
- `ERR_DATA`, 16'hDEAD: read data returned on error or timeout.
- `clk` in 1: system clock (clk100). One clock only.
- `reset` in 1: synchronous, active-high.
- `gpmc_ad_i` in DW: AD bus input.
- `gpmc_ad_o` out DW: read data to AD bus.
- `gpmc_ad_oe` out 1: AD output enable, high = drive.
- `gpmc_advn`, `gpmc_csn`, `gpmc_wein`, `gpmc_oen` in 1 each: raw GPMC strobes, active low.
- `wbm_adr` out WB_AW; `wbm_dat_w` out DW; `wbm_dat_r` in DW; `wbm_sel` out DW/8 (all ones); `wbm_we`, `wbm_stb`, `wbm_cyc` out 1; `wbm_ack`, `wbm_err` in 1.
- `busy` out 1: Wishbone cycle in progress.
- `status` out 3: {overrun, timeout, err} sticky flags.

## Operation
- Strobes pass through `SYNC_STAGES` flops; edges are detected on synchronised values. `gpmc_ad_i` is sampled unsynchronised, qualified by the synchronised edges.
- Address: synchronised rising edge of `advn` with `csn` low latches `addr <= gpmc_ad_i[GPMC_AW-1:0]`.
- Reserved addresses, served locally with no Wishbone cycle: all-ones = PAGE register (R/W, DW bits, reset 0); all-ones minus 1 = STATUS (read {13'b0,status}; write-1-to-clear).
- Mapped addresses: `wbm_adr = (WB_BASE + page*2^GPMC_AW + addr) mod 2^WB_AW`.
- States: IDLE -> ADDR (address latched) -> WB (cyc/stb high) -> HOLD -> IDLE.
- Write: in ADDR, synchronised falling edge of `wein` captures `gpmc_ad_i` into `wbm_dat_w`, sets `wbm_we`, enters WB. HOLD waits for synchronised `wein` high.
- Read: in ADDR, synchronised falling edge of `oen` enters WB with `wbm_we=0`. On ack, latch `wbm_dat_r` into `gpmc_ad_o`. On err or timeout, latch `ERR_DATA`. Enter HOLD.
- `gpmc_ad_oe = (state==HOLD) & read & ~gpmc_oen & ~gpmc_csn`. Raw, unsynchronised strobes are used so the bus is released combinationally. HOLD exits on synchronised `oen` high.
- `wbm_err` sets `status[0]`. Timeout sets `status[1]` and drops cyc/stb. An `advn` address edge while in WB/HOLD is ignored and sets `status[2]`.
- Synchronised `csn` high in ADDR or HOLD returns to IDLE. In WB, the cycle completes, then the FSM returns to IDLE and read data is discarded.

## Timing
- Reset: `wbm_cyc/stb/we=0`, `wbm_adr=WB_BASE`, `wbm_dat_w=0`, `gpmc_ad_o=0`, `gpmc_ad_oe=0`, `busy=0`, `status=0`, page=0, state IDLE.
- Write launch latency: `wein` falling -> `wbm_cyc` high in SYNC_STAGES+1 clocks. The host must hold data ≥ SYNC_STAGES+2 clocks after `wein` falls.
- Read: `oen` falling -> `cyc` in SYNC_STAGES+1 clocks. Data valid one clock after ack. The host's access time must cover SYNC_STAGES+2+slave latency.
- `cyc` and `stb` rise and fall together. Deassertion occurs the clock after ack/err/timeout. Ack and err on the same cycle count as err.
- Timeout counter clears on cycle start and fires when it reaches TIMEOUT (cycle lasts TIMEOUT+1 clocks).
- Reset mid-cycle: cyc/stb low on the next edge, and a late ack is ignored.

## Structure
- Package `gpmc_wb_pkg`: state enum, reserved-offset constants (PAGE = all-ones, STATUS = all-ones-1), status bit indices.
- Sub-module `gpmc_strobe_sync`: per-strobe synchroniser plus rise/fall pulse outputs, parametrised by SYNC_STAGES and reset high.
- Top: FSM, address/page/status registers, timeout counter.

## Test plan
- Write page=0, addr 0x0010, data 0xA5A5, ack after 2 clocks -> one cycle, `wbm_adr=0x4000_0010`, `dat_w=0xA5A5`, `we=1`, `cyc` high 3 clocks.
- Write PAGE=0x0002, then read addr 0x0004 with slave returning 0x1234 -> `wbm_adr=0x4002_0004`, AD driven 0x1234 only while `oen` and `csn` are low.
- Read with the slave never acking, TIMEOUT=255 -> `cyc` high 256 clocks, read returns 0xDEAD, `status=3'b010`. Writing 0x0002 to STATUS clears it.
- Read with `wbm_err` and `wbm_ack` asserted on the same cycle -> data 0xDEAD, `status[0]=1`, no hang.
- `advn` pulse during WB -> address unchanged, `status[2]=1`. `csn` high during WB -> cycle finishes and `gpmc_ad_oe` stays 0.
- `reset` asserted 1 clock into a cycle -> `cyc=0` the next clock, all outputs at reset values, a following normal write succeeds.
